// File: rtl/lin_relu_vec_if.sv
// rtl/lin_relu_vec_if.sv - element stream in, result stream out for lin_relu_vec
interface lin_relu_vec_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_w;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_b;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_y;
  logic                    out_sat;
  logic                    out_len_err;

  modport master (
    output in_valid, in_w, in_x, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_sat, out_len_err
  );

  modport slave (
    input  in_valid, in_w, in_x, in_b, in_last, out_ready,
    output in_ready, out_valid, out_y, out_sat, out_len_err
  );
endinterface

// File: rtl/lin_relu_vec.sv
// rtl/lin_relu_vec.sv - serial MAC + saturate + ReLU over a vector; LIN_RELU_VEC_LEAKY_EN selects leaky ReLU
module lin_relu_vec #(
  parameter int WIDTH       = 16,
  parameter int MAX_LEN     = 64,
  parameter int ACC_W       = 2*WIDTH + $clog2(MAX_LEN) + 1,
  parameter int LEAKY_SHIFT = 3
) (
  input logic          clk,
  input logic          rst_n,
  lin_relu_vec_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [1:0]                state;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          count;
  logic                      out_valid_q;
  logic signed [WIDTH-1:0]   out_y_q;
  logic                      out_sat_q;
  logic                      out_len_err_q;

  logic                      accept;
  logic                      forced;
  logic                      beat_last;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [WIDTH-1:0]   sat_val;
  logic                      sat_hit;
  logic signed [WIDTH-1:0]   y_next;

  assign bus.in_ready    = (state != S_OUT);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_y       = out_y_q;
  assign bus.out_sat     = out_sat_q;
  assign bus.out_len_err = out_len_err_q;

  assign accept    = bus.in_valid && (state != S_OUT);
  assign forced    = (count == CNT_LAST);
  assign beat_last = bus.in_last || forced;

  // Full-width signed product; the bias seeds the accumulator on the first beat only
  assign prod     = bus.in_w * bus.in_x;
  assign acc_base = (state == S_IDLE) ? {{(ACC_W-WIDTH){bus.in_b[WIDTH-1]}}, bus.in_b} : acc;
  assign acc_next = acc_base + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  // Clamp the wide sum into the signed output range and flag any clipping
  always_comb begin
    sat_hit = 1'b0;
    sat_val = acc_next[WIDTH-1:0];
    if (acc_next > SAT_MAX) begin
      sat_hit = 1'b1;
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (acc_next < SAT_MIN) begin
      sat_hit = 1'b1;
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // Activation: negative values are zeroed, or scaled down by a power of two in leaky mode
  always_comb begin
`ifdef LIN_RELU_VEC_LEAKY_EN
    y_next = sat_val[WIDTH-1] ? (sat_val >>> LEAKY_SHIFT) : sat_val;
`else
    y_next = sat_val[WIDTH-1] ? '0 : sat_val;
`endif
  end

  // Accumulate accepted beats, register the result on the final beat, hold it until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      acc           <= '0;
      count         <= '0;
      out_valid_q   <= 1'b0;
      out_y_q       <= '0;
      out_sat_q     <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACC: begin
          if (accept) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (beat_last) begin
              state         <= S_OUT;
              out_valid_q   <= 1'b1;
              out_y_q       <= y_next;
              out_sat_q     <= sat_hit;
              out_len_err_q <= forced && !bus.in_last;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc         <= '0;
            count       <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lin_relu_vec.sv
// tb/tb_lin_relu_vec.sv - scoreboard bench for lin_relu_vec (honours LIN_RELU_VEC_LEAKY_EN)
module tb_lin_relu_vec;
  localparam int WIDTH       = 16;
  localparam int MAX_LEN     = 4;
  localparam int LEAKY_SHIFT = 3;

  typedef struct {
    longint y;
    bit     sat;
    bit     err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lin_relu_vec_if #(.WIDTH(WIDTH)) bus ();

  lin_relu_vec #(
    .WIDTH(WIDTH),
    .MAX_LEN(MAX_LEN),
    .LEAKY_SHIFT(LEAKY_SHIFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  exp_t sb[$];
  int   wq[$];
  int   xq[$];
  int   checks = 0;
  int   failures = 0;
  int   hold_req = 0;

  function void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Reference: exact sum, clamp to signed WIDTH, then activation by plain arithmetic
  function automatic exp_t model(longint sum, bit err);
    exp_t   e;
    longint hi = (longint'(1) <<< (WIDTH-1)) - 1;
    longint lo = -(longint'(1) <<< (WIDTH-1));
    longint s  = sum;
    longint d  = longint'(1) <<< LEAKY_SHIFT;
    e.sat = 1'b0;
    if (s > hi) begin s = hi; e.sat = 1'b1; end
    if (s < lo) begin s = lo; e.sat = 1'b1; end
    if (s >= 0) e.y = s;
    else begin
`ifdef LIN_RELU_VEC_LEAKY_EN
      e.y = -((-s + d - 1) / d);
`else
      e.y = 0 * d;
`endif
    end
    e.err = err;
    return e;
  endfunction

  function automatic int rnd_val();
    logic signed [WIDTH-1:0] v;
    v = WIDTH'($urandom);
    if ($urandom_range(0, 1) == 0) return int'(v);
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  // Present one beat and wait until it is taken; optionally check the one-cycle result latency
  task automatic drive_beat(input int w, input int x, input int b, input bit last, input bit expect_out);
    int n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_w = WIDTH'(w);
    bus.in_x = WIDTH'(x);
    bus.in_b = WIDTH'(b);
    bus.in_last = last;
    while (!bus.in_ready && n <= 300) begin
      @(negedge clk);
      n++;
    end
    if (n > 300) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_w = WIDTH'($urandom);
    bus.in_x = WIDTH'($urandom);
    bus.in_b = WIDTH'($urandom);
    bus.in_last = 1'($urandom);
    if (expect_out) begin
      @(negedge clk);
      check("latency_out_valid", bus.out_valid, 1);
    end
  endtask

  // Push the expected result for the vector in wq/xq, then stream it
  task automatic send_vec(input int b, input bit use_last);
    longint sum = b;
    int     len = wq.size();
    for (int i = 0; i < len; i++) sum += longint'(wq[i]) * longint'(xq[i]);
    sb.push_back(model(sum, !use_last));
    for (int i = 0; i < len; i++)
      drive_beat(wq[i], xq[i], (i == 0) ? b : int'($urandom_range(0, 99)),
                 use_last && (i == len - 1), i == len - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 500, 1);
  endtask

  // Monitor: drives out_ready, pops the scoreboard on each handshake, checks hold stability
  initial begin : monitor
    bit     stalled = 1'b0;
    longint py = 0;
    bit     ps = 1'b0;
    bit     pe = 1'b0;
    exp_t   e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled) begin
        check("hold_out_valid", bus.out_valid, 1);
        check("hold_out_y", bus.out_y, py);
        check("hold_out_sat", bus.out_sat, ps);
        check("hold_out_len_err", bus.out_len_err, pe);
      end
      if (bus.out_valid && hold_req > 0) begin
        bus.out_ready = 1'b0;
        hold_req--;
        check("in_ready_low_while_out", bus.in_ready, 0);
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_y", bus.out_y, e.y);
          check("out_sat", bus.out_sat, e.sat);
          check("out_len_err", bus.out_len_err, e.err);
        end
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        py = bus.out_y;
        ps = bus.out_sat;
        pe = bus.out_len_err;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    bit use_last;
    int len;
    bus.in_valid = 1'b0;
    bus.in_w = '0;
    bus.in_x = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_out_len_err", bus.out_len_err, 0);
    check("rst_in_ready", bus.in_ready, 1);

    wq = {3};              xq = {4};              send_vec(-5, 1);
    wq = {2, -1, 4};       xq = {5, 20, 1};       send_vec(1, 1);
    wq = {32767, 32767, 32767, 32767};
    xq = {32767, 32767, 32767, 32767};            send_vec(0, 1);
    wq = {-32768};         xq = {32767};          send_vec(0, 1);
    drain();

    hold_req = 5;
    wq = {10};             xq = {10};             send_vec(0, 1);
    wq = {1};              xq = {2};              send_vec(3, 1);
    drain();
    check("hold_consumed", hold_req, 0);

    wq = {1, 1, 1, 1};     xq = {1, 1, 1, 1};     send_vec(0, 0);
    wq = {2};              xq = {3};              send_vec(0, 1);
    drain();

    drive_beat(5, 6, 9, 1'b0, 1'b0);
    drive_beat(7, 8, 0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    wq = {1};              xq = {1};              send_vec(0, 1);
    drain();

    for (int v = 0; v < 40; v++) begin
      use_last = ($urandom_range(0, 4) != 0);
      len = use_last ? int'($urandom_range(1, MAX_LEN)) : MAX_LEN;
      wq = {};
      xq = {};
      for (int i = 0; i < len; i++) begin
        wq.push_back(rnd_val());
        xq.push_back(rnd_val());
      end
      send_vec(rnd_val(), use_last);
    end
    drain();
    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
